// File: rtl/mem_access_unit_if.sv
// Request/response handshake between the core and mem_access_unit, plus the
// data-memory and memory-mapped IO buses the unit drives.
interface mem_access_unit_if #(
  parameter int DMEM_AW = 14
);
  logic               req;
  logic               mem_read;
  logic               mem_write;
  logic [2:0]         funct3;
  logic [31:0]        addr;
  logic [31:0]        wdata;
  logic               busy;
  logic               done;
  logic [31:0]        rdata;
  logic               fault;
  logic               dmem_en;
  logic [DMEM_AW-1:0] dmem_addr;
  logic [3:0]         dmem_we;
  logic [31:0]        dmem_wdata;
  logic [31:0]        dmem_rdata;
  logic               io_en;
  logic [3:0]         io_we;
  logic [31:0]        io_addr;
  logic [31:0]        io_wdata;
  logic [31:0]        io_rdata;

  modport slave (
    input  req, mem_read, mem_write, funct3, addr, wdata, dmem_rdata, io_rdata,
    output busy, done, rdata, fault, dmem_en, dmem_addr, dmem_we, dmem_wdata,
           io_en, io_we, io_addr, io_wdata
  );

  modport master (
    output req, mem_read, mem_write, funct3, addr, wdata, dmem_rdata, io_rdata,
    input  busy, done, rdata, fault, dmem_en, dmem_addr, dmem_we, dmem_wdata,
           io_en, io_we, io_addr, io_wdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store stage: one data-memory or MMIO access per request via a 4-state FSM.
// Define MAU_MISALIGN_TRAP_EN to flag misaligned half/word accesses instead of forcing alignment.
module mem_access_unit #(
  parameter int          DMEM_AW = 14,
  parameter logic [31:0] IO_BASE = 32'hFFFF_FC00
) (
  input  logic        clk,
  input  logic        rst_n,
  mem_access_unit_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, DONE} state_t;

  state_t             state_q;
  logic [2:0]         funct3_q;
  logic [1:0]         offset_q;
  logic               isLoad_q;
  logic               isIo_q;
  logic               busy_q;
  logic               done_q;
  logic               fault_q;
  logic [31:0]        rdata_q;
  logic               dmemEn_q;
  logic [DMEM_AW-1:0] dmemAddr_q;
  logic [3:0]         dmemWe_q;
  logic [31:0]        dmemWdata_q;
  logic               ioEn_q;
  logic [3:0]         ioWe_q;
  logic [31:0]        ioAddr_q;
  logic [31:0]        ioWdata_q;

  logic        accept;
  logic        toIo;
  logic        misaligned;
  logic [3:0]  storeWe;
  logic [31:0] storeData;
  logic [31:0] rawRdata;
  logic [7:0]  byteSel;
  logic [15:0] halfSel;
  logic [31:0] loadData;

  // funct3[1:0]: 00 byte, 01 half, anything else is handled as a full word.
  always_comb begin
    accept    = bus.req && (bus.mem_read || bus.mem_write);
    toIo      = (bus.addr >= IO_BASE);
    storeWe   = 4'b1111;
    storeData = bus.wdata;
    case (bus.funct3[1:0])
      2'b00: begin
        storeWe   = 4'b0001 << bus.addr[1:0];
        storeData = {4{bus.wdata[7:0]}};
      end
      2'b01: begin
        storeWe   = bus.addr[1] ? 4'b1100 : 4'b0011;
        storeData = {2{bus.wdata[15:0]}};
      end
      default: ;
    endcase
    if (!bus.mem_write) storeWe = 4'b0000;
`ifdef MAU_MISALIGN_TRAP_EN
    misaligned = ((bus.funct3[1:0] == 2'b01) && bus.addr[0]) ||
                 (bus.funct3[1] && (bus.addr[1:0] != 2'b00));
`else
    misaligned = 1'b0;
`endif
  end

  always_comb begin
    rawRdata = isIo_q ? bus.io_rdata : bus.dmem_rdata;
    byteSel  = rawRdata[7:0];
    case (offset_q)
      2'd1:    byteSel = rawRdata[15:8];
      2'd2:    byteSel = rawRdata[23:16];
      2'd3:    byteSel = rawRdata[31:24];
      default: ;
    endcase
    halfSel  = offset_q[1] ? rawRdata[31:16] : rawRdata[15:0];
    loadData = rawRdata;
    case (funct3_q[1:0])
      2'b00:   loadData = {{24{~funct3_q[2] & byteSel[7]}}, byteSel};
      2'b01:   loadData = {{16{~funct3_q[2] & halfSel[15]}}, halfSel};
      default: ;
    endcase
  end

  // Every bus output is registered; strobes default low so they pulse only in ACCESS.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      funct3_q    <= '0;
      offset_q    <= '0;
      isLoad_q    <= 1'b0;
      isIo_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      fault_q     <= 1'b0;
      rdata_q     <= '0;
      dmemEn_q    <= 1'b0;
      dmemAddr_q  <= '0;
      dmemWe_q    <= '0;
      dmemWdata_q <= '0;
      ioEn_q      <= 1'b0;
      ioWe_q      <= '0;
      ioAddr_q    <= '0;
      ioWdata_q   <= '0;
    end else begin
      dmemEn_q <= 1'b0;
      dmemWe_q <= '0;
      ioEn_q   <= 1'b0;
      ioWe_q   <= '0;
      done_q   <= 1'b0;
      fault_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            funct3_q <= bus.funct3;
            offset_q <= bus.addr[1:0];
            isLoad_q <= !bus.mem_write;
            isIo_q   <= toIo;
            busy_q   <= 1'b1;
            if (misaligned) begin
              state_q <= DONE;
              done_q  <= 1'b1;
              fault_q <= 1'b1;
            end else begin
              state_q     <= ACCESS;
              dmemEn_q    <= !toIo;
              ioEn_q      <= toIo;
              dmemWe_q    <= toIo ? 4'b0000 : storeWe;
              ioWe_q      <= toIo ? storeWe : 4'b0000;
              dmemAddr_q  <= bus.addr[DMEM_AW+1:2];
              ioAddr_q    <= bus.addr;
              dmemWdata_q <= storeData;
              ioWdata_q   <= storeData;
            end
          end
        end
        ACCESS: begin
          if (isLoad_q) begin
            state_q <= CAPTURE;
          end else begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end
        end
        CAPTURE: begin
          rdata_q <= loadData;
          state_q <= DONE;
          done_q  <= 1'b1;
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.fault      = fault_q;
  assign bus.rdata      = rdata_q;
  assign bus.dmem_en    = dmemEn_q;
  assign bus.dmem_addr  = dmemAddr_q;
  assign bus.dmem_we    = dmemWe_q;
  assign bus.dmem_wdata = dmemWdata_q;
  assign bus.io_en      = ioEn_q;
  assign bus.io_we      = ioWe_q;
  assign bus.io_addr    = ioAddr_q;
  assign bus.io_wdata   = ioWdata_q;

endmodule
